rng_arbiter: RTL
================

# rng_arbiter

Shares one 16-bit xorshift pseudo-random generator among up to NUM_REQ game-logic requesters, such as duck spawn position, flight direction and spawn delay. Each requester asks for a value in the range [0, bound). The arbiter grants requesters in round-robin order. It steps the generator and uses masked rejection sampling to return an unbiased value, with a guaranteed-terminating fallback. It sits between the game FSM/peripheral logic and the generator state it owns.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 16: generator and result width (fixed at 16 for the xorshift constants).
- SEED, 16'h0001: generator reset value. A value of 0 is replaced by 16'h0001.
- MAX_TRIES, 8: maximum DRAW cycles per grant (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- bound  in  NUM_REQ*WIDTH  per-requester exclusive upper limit; slice i = bound[i*WIDTH +: WIDTH]; 0 = full 16-bit range.
- ack  out  NUM_REQ  one-cycle grant-complete pulse, one-hot.
- rnd_out  out  WIDTH  result; valid in the ack cycle and held until the next ack.
- busy  out  1  high in DRAW and ACK.

## Operation
- Generator step: x ^= x<<7; x ^= x>>9; x ^= x<<8, truncated to 16 bits. The state is never 0.
- The generator advances only at the end of each DRAW cycle. Sequence from seed 1: 0x0001, 0x8181, 0x6021, 0xE999, 0x2E0B, 0xB59E, 0xD9A3.
- FSM states:
  - IDLE → DRAW when any req is high.
    - Pick the first high req at or after rr_ptr, wrapping.
    - Latch the index, bound and try count = 0.
    - Set rr_ptr = (index+1) mod NUM_REQ.
  - DRAW:
    - mask = smallest 2^k−1 ≥ bound−1. bound 0 → 0xFFFF; bound 1 → 0.
    - cand = x & mask.
    - If bound==0 or cand<bound → latch rnd_out=cand, go to ACK.
    - Else if tries+1 == MAX_TRIES → latch rnd_out = x & (mask>>1), which is always < bound, go to ACK.
    - Else tries++, stay in DRAW.
  - ACK: ack[index]=1, registered. req is ignored. Go to IDLE.
- Requesters hold req until they see ack and deassert on the following edge.
- A req dropped mid-draw does not abort the draw; ack still pulses.
- bound changes after the grant are ignored because bound is latched.

## Timing
- Reset values: state IDLE, x=SEED (or 1), rr_ptr=0, ack=0, rnd_out=0, busy=0, latched index/bound/tries=0.
- Reset mid-DRAW or mid-ACK returns immediately to reset values. No ack is issued.
- Latency: req seen in IDLE at cycle t → ack at t+2+r, where r is the number of rejections (0..MAX_TRIES−1). The arbiter is back in IDLE at t+3+r.
- Throughput: at most one grant per 3 cycles with no rejections.
- Simultaneous requests are resolved purely by rr_ptr. A requester re-asserting continuously cannot starve the others.
- ack and rnd_out are registered outputs; there is no combinational path from req.

## Structure
- Shared package rng_pkg holds:
  - FSM state encoding (IDLE/DRAW/ACK);
  - shift constants 7/9/8;
  - default seed;
  - the xorshift next-state function;
  - the mask-from-bound function.
- One sub-module, rr_picker: combinational round-robin selector (req, rr_ptr → one-hot grant and index). It is reused later by other shared-resource arbiters.
- The generator state register, FSM and output registers live in rng_arbiter.

## Test plan
- Reset defaults: hold rst_n low 3 cycles → ack=0, rnd_out=0, busy=0. Release, then req[0]=1, bound=0 at cycle t → ack[0] at t+2 with rnd_out=0x0001. The next draw returns 0x8181.
- Round-robin: after reset, req=4'b1111, all bounds 0 → ack order 0,1,2,3 at 3-cycle spacing with values 0x0001, 0x8181, 0x6021, 0xE999. After that, rr_ptr=0.
- Rejection: three full-range draws, then req[1] with bound=9 (mask 15) → candidates 9, 11 and 14 are rejected and 3 is accepted. ack[1] arrives 5 cycles after the request is seen, with rnd_out=3.
- Fallback: MAX_TRIES=1, state at 0xE999, bound=9 → cand 9 is rejected and the fallback 0xE999&7=1 is used. ack at t+2, rnd_out=1.
- Edge bounds: bound=1 → rnd_out=0 with no rejection. bound=0 → raw state. Over 1000 random bounded draws, always rnd_out < bound.
- Async reset mid-DRAW: pulse rst_n low during a rejection loop → no ack. The generator returns to SEED, and the next grant returns 0x0001.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the pseudo-random arbiter: FSM encoding, xorshift
// constants, generator step and the rejection-sampling mask.
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int          SHIFT_A      = 7;
    localparam int          SHIFT_B      = 9;
    localparam int          SHIFT_C      = 8;
    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

    function automatic logic [15:0] xorshift16(input logic [15:0] x);
        logic [15:0] t;
        t = x ^ (x << SHIFT_A);
        t = t ^ (t >> SHIFT_B);
        t = t ^ (t << SHIFT_C);
        return t;
    endfunction

    // Smear the highest set bit of (bound-1) downwards; bound 0 wraps to all ones.
    function automatic logic [15:0] mask_from_bound(input logic [15:0] b);
        logic [15:0] m;
        m = b - 16'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping, returned as both a one-hot grant and a binary index.
module rr_picker
    import rng_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Rotating priority scan; the first hit locks out later positions.
    always_comb begin
        int   pos;
        logic hit_s;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos        = (int'(ptr) + k) % N;
            hit_s      = !valid && req[pos];
            grant[pos] = grant[pos] | hit_s;
            idx        = hit_s ? IW'(pos) : idx;
            valid      = valid | hit_s;
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin access to one 16-bit xorshift generator, returning unbiased
// values in [0, bound) via masked rejection sampling with a bounded fallback.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int               NUM_REQ   = 4,
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] SEED      = 16'h0001,
    parameter int               MAX_TRIES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] bound,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rnd_out,
    output logic                     busy
);

    localparam int               IW      = $clog2(NUM_REQ);
    localparam int               TW      = $clog2(MAX_TRIES + 1);
    localparam logic [WIDTH-1:0] RESET_X = (SEED == '0) ? DEFAULT_SEED : SEED;

    state_t             state_r;
    logic [WIDTH-1:0]   x_r;
    logic [IW-1:0]      rr_ptr_r;
    logic [IW-1:0]      idx_r;
    logic [WIDTH-1:0]   bound_r;
    logic [TW-1:0]      tries_r;

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_valid_s;
    logic [WIDTH-1:0]   pick_bound_s;
    logic [WIDTH-1:0]   mask_s;
    logic [WIDTH-1:0]   cand_s;
    logic               accept_s;
    logic               last_try_s;
    logic [NUM_REQ-1:0] ack_onehot_s;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Mux out the bound of the requester the picker selected.
    always_comb begin
        pick_bound_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_bound_s = pick_grant_s[i] ? bound[i*WIDTH +: WIDTH] : pick_bound_s;
        end
    end

    // Candidate evaluation for the current draw; mask>>1 is always below bound.
    always_comb begin
        mask_s       = mask_from_bound(bound_r);
        cand_s       = x_r & mask_s;
        accept_s     = (bound_r == '0) || (cand_s < bound_r);
        last_try_s   = (tries_r == TW'(MAX_TRIES - 1));
        ack_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_r;
    end

    // Arbitration FSM, generator state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            x_r      <= RESET_X;
            rr_ptr_r <= '0;
            idx_r    <= '0;
            bound_r  <= '0;
            tries_r  <= '0;
            ack      <= '0;
            rnd_out  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= '0;
                    if (pick_valid_s) begin
                        idx_r    <= pick_idx_s;
                        bound_r  <= pick_bound_s;
                        tries_r  <= '0;
                        rr_ptr_r <= (pick_idx_s == IW'(NUM_REQ - 1)) ? '0 : pick_idx_s + IW'(1);
                        busy     <= 1'b1;
                        state_r  <= ST_DRAW;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAW: begin
                    x_r <= xorshift16(x_r);
                    if (accept_s) begin
                        rnd_out <= cand_s;
                        ack     <= ack_onehot_s;
                        state_r <= ST_ACK;
                    end else if (last_try_s) begin
                        rnd_out <= x_r & (mask_s >> 1);
                        ack     <= ack_onehot_s;
                        state_r <= ST_ACK;
                    end else begin
                        tries_r <= tries_r + TW'(1);
                        state_r <= ST_DRAW;
                    end
                end
                ST_ACK: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
